// File: rtl/uart_receiver.sv
// UART receive engine: oversampled start/data/parity/stop recovery with
// parity and framing status and a one-cycle completion pulse.
module uart_receiver #(
  parameter int SAMPLING_RATE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_i,
  input  logic       tick_i,
  input  logic       rx_en_i,
  input  logic [1:0] data_bit_num_i,
  input  logic [1:0] stop_bit_num_i,
  input  logic       parity_en_i,
  input  logic       parity_type_i,
  output logic [7:0] data_o,
  output logic       rx_done_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int TW = $clog2(SAMPLING_RATE);
  localparam logic [TW-1:0] FULL_LAST = TW'(SAMPLING_RATE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(SAMPLING_RATE / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_n;
  logic            sync_ff, rxs;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            par_acc, par_acc_n;
  logic            par_err, par_err_n;
  logic            stop_err, stop_err_n;
  logic            armed, armed_n;
  logic [1:0]      cfg_bits, cfg_bits_n;
  logic [1:0]      cfg_stop, cfg_stop_n;
  logic            cfg_par_en, cfg_par_en_n;
  logic            cfg_par_type, cfg_par_type_n;
  logic [7:0]      data_q, data_n;
  logic            perr_q, perr_n;
  logic            ferr_q, ferr_n;
  logic            done_q, done_n;

  always_comb begin
    state_n        = state;
    tick_n         = tick_cnt;
    bit_n          = bit_cnt;
    shreg_n        = shreg;
    par_acc_n      = par_acc;
    par_err_n      = par_err;
    stop_err_n     = stop_err;
    armed_n        = armed;
    cfg_bits_n     = cfg_bits;
    cfg_stop_n     = cfg_stop;
    cfg_par_en_n   = cfg_par_en;
    cfg_par_type_n = cfg_par_type;
    data_n         = data_q;
    perr_n         = perr_q;
    ferr_n         = ferr_q;
    done_n         = 1'b0;

    // A held-low line (break) must go high in IDLE before another start is taken
    if (state == IDLE && rxs) armed_n = 1'b1;

    if (!rx_en_i) begin
      state_n = IDLE;
      tick_n  = '0;
      bit_n   = '0;
    end else if (tick_i) begin
      unique case (state)
        IDLE: begin
          if (!rxs && armed) begin
            state_n = START;
            tick_n  = '0;
            armed_n = 1'b0;
          end
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_n = '0;
            if (rxs) begin
              state_n = IDLE;
            end else begin
              state_n        = DATA;
              bit_n          = '0;
              par_acc_n      = 1'b0;
              par_err_n      = 1'b0;
              stop_err_n     = 1'b0;
              cfg_bits_n     = data_bit_num_i;
              cfg_stop_n     = stop_bit_num_i;
              cfg_par_en_n   = parity_en_i;
              cfg_par_type_n = parity_type_i;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            tick_n    = '0;
            shreg_n   = {rxs, shreg[7:1]};
            par_acc_n = par_acc ^ rxs;
            if (bit_cnt == {1'b1, cfg_bits}) begin
              bit_n   = '0;
              state_n = cfg_par_en ? PARITY : STOP;
            end else begin
              bit_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (tick_cnt == FULL_LAST) begin
            tick_n    = '0;
            par_err_n = (par_acc ^ rxs) ^ cfg_par_type;
            state_n   = STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          // bit_cnt indexes the stop sample; the second one is half a bit later for 1.5 stops
          if (tick_cnt == ((bit_cnt == 3'd0 || cfg_stop[1]) ? FULL_LAST : HALF_LAST)) begin
            tick_n     = '0;
            stop_err_n = stop_err | ~rxs;
            if (bit_cnt == 3'd0 && cfg_stop != 2'b00) begin
              bit_n = 3'd1;
            end else begin
              bit_n   = '0;
              state_n = IDLE;
              data_n  = shreg >> ~cfg_bits;
              perr_n  = cfg_par_en & par_err;
              ferr_n  = stop_err | ~rxs;
              done_n  = 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_ff      <= 1'b1;
      rxs          <= 1'b1;
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      par_err      <= 1'b0;
      stop_err     <= 1'b0;
      armed        <= 1'b0;
      cfg_bits     <= '0;
      cfg_stop     <= '0;
      cfg_par_en   <= 1'b0;
      cfg_par_type <= 1'b0;
      data_q       <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sync_ff      <= rx_i;
      rxs          <= sync_ff;
      state        <= state_n;
      tick_cnt     <= tick_n;
      bit_cnt      <= bit_n;
      shreg        <= shreg_n;
      par_acc      <= par_acc_n;
      par_err      <= par_err_n;
      stop_err     <= stop_err_n;
      armed        <= armed_n;
      cfg_bits     <= cfg_bits_n;
      cfg_stop     <= cfg_stop_n;
      cfg_par_en   <= cfg_par_en_n;
      cfg_par_type <= cfg_par_type_n;
      data_q       <= data_n;
      perr_q       <= perr_n;
      ferr_q       <= ferr_n;
      done_q       <= done_n;
    end
  end

  assign data_o       = data_q;
  assign rx_done_o    = done_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state != IDLE);

endmodule
